// File: rtl/riscv_v_pkg.sv
// rtl/riscv_v_pkg.sv - shared vector types and constants for the uop sequencer
// Contents: vtype enums (lmul, sew), sequencer state enum, micro-op record,
// default VLEN and register/control widths.
package riscv_v_pkg;

    localparam int RISCV_V_VLEN   = 128;
    localparam int RISCV_V_ADDR_W = 5;
    localparam int RISCV_V_CTRL_W = 64;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } riscv_v_lmul_t;

    typedef enum logic [2:0] {
        SEW_8     = 3'b000,
        SEW_16    = 3'b001,
        SEW_32    = 3'b010,
        SEW_64    = 3'b011,
        SEW_RSVD4 = 3'b100,
        SEW_RSVD5 = 3'b101,
        SEW_RSVD6 = 3'b110,
        SEW_RSVD7 = 3'b111
    } riscv_v_sew_t;

    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_ISSUE = 1'b1
    } riscv_v_state_seq_t;

    typedef struct packed {
        logic [RISCV_V_ADDR_W-1:0] vs1;
        logic [RISCV_V_ADDR_W-1:0] vs2;
        logic [RISCV_V_ADDR_W-1:0] vd;
        logic [2:0]                idx;
        logic                      first;
        logic                      last;
        logic [RISCV_V_CTRL_W-1:0] ctrl;
    } riscv_v_uop_t;

endpackage

// File: rtl/riscv_v_uop_count.sv
// rtl/riscv_v_uop_count.sv - vtype decode, legality/alignment check and micro-op count
// Ports: i_vlmul/i_vsew/i_vl vtype fields; i_vd/i_vs1/i_vs2 base registers;
// i_use_vs1/i_is_reduct operand kind; o_illegal reject flag; o_n micro-op count (0..8).
module riscv_v_uop_count
    import riscv_v_pkg::*;
#(
    parameter int NUM_VREGS = 32,
    parameter int VLEN      = RISCV_V_VLEN,
    parameter int MAX_LMUL  = 8,
    parameter int VL_W      = $clog2(VLEN*MAX_LMUL/8)+1,
    localparam int ADDR_W   = $clog2(NUM_VREGS)
) (
    input  logic [2:0]        i_vlmul,
    input  logic [2:0]        i_vsew,
    input  logic [VL_W-1:0]   i_vl,
    input  logic [ADDR_W-1:0] i_vd,
    input  logic [ADDR_W-1:0] i_vs1,
    input  logic [ADDR_W-1:0] i_vs2,
    input  logic              i_use_vs1,
    input  logic              i_is_reduct,
    output logic              o_illegal,
    output logic [3:0]        o_n
);

    // log2 of elements per register at SEW=8
    localparam int            LG_EPR8 = $clog2(VLEN/8);
    localparam logic [VL_W:0] ONE     = 1;

    logic [1:0]        w_lmul_lg;
    logic              w_lmul_bad;
    logic [3:0]        w_lmul;
    logic [2:0]        w_shamt;
    logic [VL_W:0]     w_round;
    logic [VL_W:0]     w_regs;
    logic [ADDR_W-1:0] w_amask;
    logic              w_misaligned;

    always_comb begin
        w_lmul_lg  = 2'd0;
        w_lmul_bad = 1'b0;
        case (riscv_v_lmul_t'(i_vlmul))
            LMUL_1:    w_lmul_lg = 2'd0;
            LMUL_2:    w_lmul_lg = 2'd1;
            LMUL_4:    w_lmul_lg = 2'd2;
            LMUL_8:    w_lmul_lg = 2'd3;
            LMUL_RSVD: w_lmul_bad = 1'b1;
            default:   w_lmul_lg = 2'd0;   // fractional LMUL occupies one register
        endcase
        w_lmul = 4'd1 << w_lmul_lg;
        if (int'(w_lmul) > MAX_LMUL) begin
            w_lmul_bad = 1'b1;
        end

        // ceil(vl / (VLEN/SEW)) as add-then-shift; VLEN/SEW = 2^(LG_EPR8 - sew_lg)
        w_shamt = 3'(LG_EPR8) - {1'b0, i_vsew[1:0]};
        w_round = (ONE << w_shamt) - ONE;
        w_regs  = ({1'b0, i_vl} + w_round) >> w_shamt;
        o_n     = (w_regs < (VL_W+1)'(w_lmul)) ? w_regs[3:0] : w_lmul;

        // Reductions read a single vd/vs1 register, so only vs2 must be group-aligned
        w_amask      = ADDR_W'(w_lmul - 4'd1);
        w_misaligned = (|(i_vs2 & w_amask))
                     | (!i_is_reduct && (|(i_vd & w_amask)))
                     | (i_use_vs1 && !i_is_reduct && (|(i_vs1 & w_amask)));

        o_illegal = w_lmul_bad | i_vsew[2] | w_misaligned;
    end

endmodule

// File: rtl/riscv_v_uop_sequencer.sv
// rtl/riscv_v_uop_sequencer.sv - expands one vector instruction into per-register micro-ops
// Ports: clk/rst (async active-low); flush abort; in_* instruction handshake and
// operands; vlmul/vsew/vl vtype state sampled at accept; uop_* micro-op handshake
// and fields; illegal one-cycle reject pulse; busy while a group is issuing.
module riscv_v_uop_sequencer
    import riscv_v_pkg::*;
#(
    parameter int NUM_VREGS = 32,
    parameter int VLEN      = RISCV_V_VLEN,
    parameter int MAX_LMUL  = 8,
    parameter int VL_W      = $clog2(VLEN*MAX_LMUL/8)+1,
    parameter int CTRL_W    = 64,
    localparam int ADDR_W   = $clog2(NUM_VREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_vs1,
    input  logic [ADDR_W-1:0] in_vs2,
    input  logic [ADDR_W-1:0] in_vd,
    input  logic              in_use_vs1,
    input  logic              in_is_reduct,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [2:0]        vlmul,
    input  logic [2:0]        vsew,
    input  logic [VL_W-1:0]   vl,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [ADDR_W-1:0] uop_vs1,
    output logic [ADDR_W-1:0] uop_vs2,
    output logic [ADDR_W-1:0] uop_vd,
    output logic [CTRL_W-1:0] uop_ctrl,
    output logic [2:0]        uop_idx,
    output logic              uop_first,
    output logic              uop_last,
    output logic              illegal,
    output logic              busy
);

    riscv_v_state_seq_t r_state, w_next_state;
    logic [2:0]         r_idx;
    logic [2:0]         r_last_idx;
    logic [ADDR_W-1:0]  r_vs1, r_vs2, r_vd;
    logic               r_inc_vs1, r_inc_vd;
    logic [CTRL_W-1:0]  r_ctrl;
    logic               r_illegal;

    logic               w_illegal;
    logic [3:0]         w_n;
    logic               w_accept;
    logic               w_start;
    logic               w_issue;
    logic               w_last;

    riscv_v_uop_count #(
        .NUM_VREGS (NUM_VREGS),
        .VLEN      (VLEN),
        .MAX_LMUL  (MAX_LMUL),
        .VL_W      (VL_W)
    ) u_count (
        .i_vlmul     (vlmul),
        .i_vsew      (vsew),
        .i_vl        (vl),
        .i_vd        (in_vd),
        .i_vs1       (in_vs1),
        .i_vs2       (in_vs2),
        .i_use_vs1   (in_use_vs1),
        .i_is_reduct (in_is_reduct),
        .o_illegal   (w_illegal),
        .o_n         (w_n)
    );

    assign w_issue  = (r_state == SEQ_ISSUE);
    assign w_last   = w_issue && (r_idx == r_last_idx);
    // Accepting during the last micro-op's handshake keeps issue back-to-back
    assign in_ready = rst && !flush && (!w_issue || (w_last && uop_ready));
    assign w_accept = in_valid && in_ready;
    assign w_start  = w_accept && !w_illegal && (w_n != 4'd0);

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = SEQ_IDLE;
        end else if (w_start) begin
            w_next_state = SEQ_ISSUE;
        end else if (w_last && uop_ready) begin
            w_next_state = SEQ_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= 3'd0;
            r_last_idx <= 3'd0;
            r_vs1      <= '0;
            r_vs2      <= '0;
            r_vd       <= '0;
            r_inc_vs1  <= 1'b0;
            r_inc_vd   <= 1'b0;
            r_ctrl     <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_illegal <= w_accept && w_illegal;
            if (flush) begin
                r_idx <= 3'd0;
            end else if (w_start) begin
                r_idx      <= 3'd0;
                r_last_idx <= 3'(w_n - 4'd1);
                r_vs1      <= in_vs1;
                r_vs2      <= in_vs2;
                r_vd       <= in_vd;
                r_inc_vs1  <= in_use_vs1 && !in_is_reduct;
                r_inc_vd   <= !in_is_reduct;
                r_ctrl     <= in_ctrl;
            end else if (w_issue && uop_ready) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    assign uop_valid = w_issue;
    assign busy      = w_issue;
    assign uop_idx   = r_idx;
    assign uop_first = w_issue && (r_idx == 3'd0);
    assign uop_last  = w_last;
    assign uop_vs2   = r_vs2 + ADDR_W'(r_idx);
    assign uop_vs1   = r_vs1 + (r_inc_vs1 ? ADDR_W'(r_idx) : '0);
    assign uop_vd    = r_vd  + (r_inc_vd  ? ADDR_W'(r_idx) : '0);
    assign uop_ctrl  = r_ctrl;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_riscv_v_uop_sequencer.sv
// tb/tb_riscv_v_uop_sequencer.sv - self-checking bench for riscv_v_uop_sequencer
module tb_riscv_v_uop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_vs1, in_vs2, in_vd;
    logic        in_use_vs1, in_is_reduct;
    logic [63:0] in_ctrl;
    logic [2:0]  vlmul, vsew;
    logic [7:0]  vl;
    logic        uop_valid, uop_ready;
    logic [4:0]  uop_vs1, uop_vs2, uop_vd;
    logic [63:0] uop_ctrl;
    logic [2:0]  uop_idx;
    logic        uop_first, uop_last, illegal, busy;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_v_uop_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd),
        .in_use_vs1(in_use_vs1), .in_is_reduct(in_is_reduct), .in_ctrl(in_ctrl),
        .vlmul(vlmul), .vsew(vsew), .vl(vl),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_vd(uop_vd),
        .uop_ctrl(uop_ctrl), .uop_idx(uop_idx),
        .uop_first(uop_first), .uop_last(uop_last),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vlmul;
        logic [2:0] vsew;
        logic [7:0] vl;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic       use1;
        logic       red;
        int         n;
        logic       ill;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [63:0] c);
        vlmul = v.vlmul; vsew = v.vsew; vl = v.vl;
        in_vd = v.vd; in_vs1 = v.vs1; in_vs2 = v.vs2;
        in_use_vs1 = v.use1; in_is_reduct = v.red; in_ctrl = c;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [4:0]  e_vd, e_vs1, e_vs2;
        logic [63:0] c;
        c = {32'hC0DE_0000, 32'(id)};
        @(negedge clk);
        drive(v, c);
        in_valid = 1'b1;
        chk($sformatf("v%0d_in_ready", id), in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // vtype changes after accept must not affect the group
        vl = 8'd0; vlmul = 3'b100; vsew = 3'b111;
        @(negedge clk);
        chk($sformatf("v%0d_illegal", id), illegal, v.ill);
        if (v.n == 0) chk($sformatf("v%0d_novalid", id), uop_valid, 0);
        for (int k = 0; k < v.n; k++) begin
            if (k > 0) @(negedge clk);
            e_vd  = v.red ? v.vd : v.vd + 5'(k);
            e_vs1 = (v.use1 && !v.red) ? v.vs1 + 5'(k) : v.vs1;
            e_vs2 = v.vs2 + 5'(k);
            chk($sformatf("v%0d_k%0d_valid", id, k), uop_valid, 1);
            chk($sformatf("v%0d_k%0d_busy", id, k), busy, 1);
            chk($sformatf("v%0d_k%0d_vd", id, k), uop_vd, e_vd);
            chk($sformatf("v%0d_k%0d_vs1", id, k), uop_vs1, e_vs1);
            chk($sformatf("v%0d_k%0d_vs2", id, k), uop_vs2, e_vs2);
            chk($sformatf("v%0d_k%0d_idx", id, k), uop_idx, k);
            chk($sformatf("v%0d_k%0d_first", id, k), uop_first, k == 0);
            chk($sformatf("v%0d_k%0d_last", id, k), uop_last, k == v.n - 1);
            chk($sformatf("v%0d_k%0d_ctrl", id, k), uop_ctrl, c);
        end
        @(negedge clk);
        chk($sformatf("v%0d_end_valid", id), uop_valid, 0);
        chk($sformatf("v%0d_end_busy", id), busy, 0);
        chk($sformatf("v%0d_end_illegal", id), illegal, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t b1, b2;
        //          vlmul   vsew    vl     vd     vs1    vs2    use   red   n  ill
        tv[0]  = '{3'b010, 3'b010, 8'd16, 5'd8,  5'd4,  5'd12, 1'b1, 1'b0, 4, 1'b0};
        tv[1]  = '{3'b010, 3'b010, 8'd5,  5'd8,  5'd4,  5'd12, 1'b1, 1'b0, 2, 1'b0};
        tv[2]  = '{3'b010, 3'b010, 8'd0,  5'd8,  5'd4,  5'd12, 1'b1, 1'b0, 0, 1'b0};
        tv[3]  = '{3'b001, 3'b010, 8'd8,  5'd9,  5'd4,  5'd12, 1'b1, 1'b0, 0, 1'b1};
        tv[4]  = '{3'b100, 3'b010, 8'd8,  5'd8,  5'd4,  5'd12, 1'b1, 1'b0, 0, 1'b1};
        tv[5]  = '{3'b010, 3'b100, 8'd8,  5'd8,  5'd4,  5'd12, 1'b1, 1'b0, 0, 1'b1};
        tv[6]  = '{3'b011, 3'b010, 8'd32, 5'd3,  5'd5,  5'd16, 1'b1, 1'b1, 8, 1'b0};
        tv[7]  = '{3'b111, 3'b000, 8'd3,  5'd7,  5'd1,  5'd3,  1'b1, 1'b0, 1, 1'b0};
        tv[8]  = '{3'b011, 3'b011, 8'd5,  5'd0,  5'd3,  5'd8,  1'b0, 1'b0, 3, 1'b0};
        tv[9]  = '{3'b001, 3'b000, 8'd17, 5'd2,  5'd6,  5'd4,  1'b1, 1'b0, 2, 1'b0};
        tv[10] = '{3'b010, 3'b010, 8'd16, 5'd8,  5'd4,  5'd13, 1'b1, 1'b0, 0, 1'b1};
        tv[11] = '{3'b000, 3'b000, 8'd16, 5'd5,  5'd7,  5'd9,  1'b1, 1'b0, 1, 1'b0};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; uop_ready = 1'b1;
        in_vs1 = '0; in_vs2 = '0; in_vd = '0; in_use_vs1 = 1'b0; in_is_reduct = 1'b0;
        in_ctrl = '0; vlmul = '0; vsew = '0; vl = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", uop_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_vd", uop_vd, 0);
        chk("rst_ctrl", uop_ctrl, 0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(tv[i], i);

        // Stall on idx 1 for three cycles, then flush on idx 2
        @(negedge clk);
        drive(tv[0], 64'hABCD);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("stall_idx0", uop_idx, 0);
        @(negedge clk);
        uop_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d_valid", c), uop_valid, 1);
            chk($sformatf("stall%0d_idx", c), uop_idx, 1);
            chk($sformatf("stall%0d_vd", c), uop_vd, 9);
            chk($sformatf("stall%0d_vs1", c), uop_vs1, 5);
            chk($sformatf("stall%0d_vs2", c), uop_vs2, 13);
            chk($sformatf("stall%0d_first", c), uop_first, 0);
            chk($sformatf("stall%0d_last", c), uop_last, 0);
            if (c < 3) @(negedge clk);
        end
        uop_ready = 1'b1;
        @(negedge clk);
        chk("flush_pre_idx", uop_idx, 2);
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", uop_valid, 0);
        chk("flush_busy", busy, 0);
        @(negedge clk);
        chk("flush_stays_idle", uop_valid, 0);

        // Back-to-back LMUL=2 instructions
        b1 = '{3'b001, 3'b010, 8'd8, 5'd2,  5'd6,  5'd4,  1'b1, 1'b0, 2, 1'b0};
        b2 = '{3'b001, 3'b010, 8'd8, 5'd20, 5'd24, 5'd22, 1'b1, 1'b0, 2, 1'b0};
        @(negedge clk);
        drive(b1, 64'h1);
        in_valid = 1'b1;
        @(posedge clk);
        #1 drive(b2, 64'h2);
        @(negedge clk);
        chk("b2b_c0_valid", uop_valid, 1);
        chk("b2b_c0_vd", uop_vd, 2);
        chk("b2b_c0_in_ready", in_ready, 0);
        @(negedge clk);
        chk("b2b_c1_valid", uop_valid, 1);
        chk("b2b_c1_vd", uop_vd, 3);
        chk("b2b_c1_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_c2_valid", uop_valid, 1);
        chk("b2b_c2_vd", uop_vd, 20);
        chk("b2b_c2_first", uop_first, 1);
        chk("b2b_c2_ctrl", uop_ctrl, 2);
        @(negedge clk);
        chk("b2b_c3_valid", uop_valid, 1);
        chk("b2b_c3_vs2", uop_vs2, 23);
        chk("b2b_c3_last", uop_last, 1);
        @(negedge clk);
        chk("b2b_end_valid", uop_valid, 0);

        // Asynchronous reset mid-group
        @(negedge clk);
        drive(tv[0], 64'h55);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_pre_idx", uop_idx, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", uop_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vd", uop_vd, 0);
        chk("mid_rst_vs2", uop_vs2, 0);
        chk("mid_rst_idx", uop_idx, 0);
        chk("mid_rst_ctrl", uop_ctrl, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", uop_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
